// File: rtl/pc_end_monitor.sv
// pc_end_monitor: run monitor beside the core; ends a run on end-of-test PC (pass), cycle budget
// (timeout) or stuck PC (hang). Define PC_MON_TRACE_EN for a simulation-only trace and $stop on verdict.
module pc_end_monitor #(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter logic [XLEN-1:0] END_PC      = XLEN'(32'hff),
    parameter int              MAX_CYCLES  = 100000,
    parameter int              STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clear,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  instr,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [XLEN-1:0]  last_pc
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PASS    = 3'd2;
    localparam logic [2:0] S_TIMEOUT = 3'd3;
    localparam logic [2:0] S_HANG    = 3'd4;

    localparam logic             L_TO_EN     = (MAX_CYCLES != 32'sd0);
    localparam logic             L_HANG_EN   = (STALL_LIMIT != 32'sd0);
    localparam logic [CNT_W-1:0] L_CYC_LAST  = CNT_W'(MAX_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] L_SAME_LAST = CNT_W'(STALL_LIMIT - 32'sd1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1'b1);
    endfunction

    logic [2:0]       r_state, w_state_n;
    logic             r_done, w_done_n;
    logic             r_pass, w_pass_n;
    logic [1:0]       r_fail_code, w_fail_n;
    logic [CNT_W-1:0] r_cycle_cnt, w_cyc_n;
    logic [CNT_W-1:0] r_retire_cnt, w_ret_n;
    logic [XLEN-1:0]  r_last_pc, w_last_n;
    logic [CNT_W-1:0] r_same_cnt, w_same_n;
    logic             w_pc_same, w_end_hit, w_hang_hit, w_to_hit;
    logic             w_unused_instr;

    assign w_unused_instr = ^instr;
    assign w_pc_same  = (pc == r_last_pc);
    assign w_end_hit  = pc_valid && (pc == END_PC);
    assign w_hang_hit = L_HANG_EN && pc_valid && w_pc_same && (r_same_cnt == L_SAME_LAST);
    assign w_to_hit   = L_TO_EN && (r_cycle_cnt == L_CYC_LAST);

    // Next-state and next-output computation; exit checks use pre-update values.
    always_comb begin
        w_state_n = r_state;
        w_done_n  = r_done;
        w_pass_n  = r_pass;
        w_fail_n  = r_fail_code;
        w_cyc_n   = r_cycle_cnt;
        w_ret_n   = r_retire_cnt;
        w_last_n  = r_last_pc;
        w_same_n  = r_same_cnt;
        if (clear) begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b0;
            w_pass_n  = 1'b0;
            w_fail_n  = 2'd0;
            w_cyc_n   = {CNT_W{1'b0}};
            w_ret_n   = {CNT_W{1'b0}};
            w_last_n  = {XLEN{1'b0}};
            w_same_n  = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (en) begin
                        w_cyc_n = sat_inc(r_cycle_cnt);
                        if (pc_valid) begin
                            w_ret_n  = sat_inc(r_retire_cnt);
                            w_last_n = pc;
                            w_same_n = (w_pc_same && (r_retire_cnt != {CNT_W{1'b0}}))
                                       ? sat_inc(r_same_cnt) : {CNT_W{1'b0}};
                        end else begin
                            w_ret_n = r_retire_cnt;
                        end
                        if (w_end_hit) begin
                            w_state_n = S_PASS;
                            w_done_n  = 1'b1;
                            w_pass_n  = 1'b1;
                            w_fail_n  = 2'd0;
                        end else if (w_hang_hit) begin
                            w_state_n = S_HANG;
                            w_done_n  = 1'b1;
                            w_fail_n  = 2'd2;
                        end else if (w_to_hit) begin
                            w_state_n = S_TIMEOUT;
                            w_done_n  = 1'b1;
                            w_fail_n  = 2'd1;
                        end else begin
                            w_state_n = S_RUN;
                        end
                    end else begin
                        w_state_n = r_state;
                    end
                end
                S_PASS, S_TIMEOUT, S_HANG: begin
                    w_state_n = r_state;
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b0;
                    w_pass_n  = 1'b0;
                    w_fail_n  = 2'd0;
                    w_cyc_n   = {CNT_W{1'b0}};
                    w_ret_n   = {CNT_W{1'b0}};
                    w_last_n  = {XLEN{1'b0}};
                    w_same_n  = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and status registers; rstn is an active-high asynchronous reset.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_code  <= 2'd0;
            r_cycle_cnt  <= {CNT_W{1'b0}};
            r_retire_cnt <= {CNT_W{1'b0}};
            r_last_pc    <= {XLEN{1'b0}};
            r_same_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_state_n;
            r_done       <= w_done_n;
            r_pass       <= w_pass_n;
            r_fail_code  <= w_fail_n;
            r_cycle_cnt  <= w_cyc_n;
            r_retire_cnt <= w_ret_n;
            r_last_pc    <= w_last_n;
            r_same_cnt   <= w_same_n;
        end
    end

    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_code  = r_fail_code;
    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
    assign last_pc    = r_last_pc;

`ifdef PC_MON_TRACE_EN
    // Simulation trace of each RUN cycle plus verdict and stop on entering a terminal state.
    always @(posedge clk) begin
        if (!rstn && !clear && en && ((r_state == S_IDLE) || (r_state == S_RUN))) begin
            $display("counter:%0d instr:%h pcw:%h", r_cycle_cnt, instr, pc);
            if (w_state_n == S_PASS) begin
                $display("pc_end_monitor: PASS at pc %h", pc);
                $stop;
            end else if (w_state_n == S_HANG) begin
                $display("pc_end_monitor: HANG at pc %h", pc);
                $stop;
            end else if (w_state_n == S_TIMEOUT) begin
                $display("pc_end_monitor: TIMEOUT after %0d cycles", w_cyc_n);
                $stop;
            end else begin
                $display("pc_end_monitor: running");
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_end_monitor.sv
// Directed bench for pc_end_monitor: three instances (default, short budget/stall, end PC at 0).
module tb_pc_end_monitor;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] instr = 32'd0;

    logic        a_done, a_pass, b_done, b_pass, c_done, c_pass;
    logic [1:0]  a_fail, b_fail, c_fail;
    logic [31:0] a_cyc, a_ret, a_last, b_cyc, b_ret, b_last, c_cyc, c_ret, c_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_end_monitor dut_a (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear), .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .done(a_done), .pass(a_pass), .fail_code(a_fail), .cycle_cnt(a_cyc), .retire_cnt(a_ret),
        .last_pc(a_last)
    );

    pc_end_monitor #(.MAX_CYCLES(20), .STALL_LIMIT(4)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear), .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .done(b_done), .pass(b_pass), .fail_code(b_fail), .cycle_cnt(b_cyc), .retire_cnt(b_ret),
        .last_pc(b_last)
    );

    pc_end_monitor #(.END_PC(32'h0), .MAX_CYCLES(1), .STALL_LIMIT(1)) dut_c (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear), .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .done(c_done), .pass(c_pass), .fail_code(c_fail), .cycle_cnt(c_cyc), .retire_cnt(c_ret),
        .last_pc(c_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        en = 1'b0;
        pc_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_done, a_pass, a_fail, a_cyc, a_ret, a_last} !== 100'd0) begin
            $display("FAIL reset_a got %h exp 0", {a_done, a_pass, a_fail, a_cyc, a_ret, a_last});
            errors++;
        end
        checks++;
        if ({b_done, b_pass, b_fail, b_cyc, b_ret, b_last} !== 100'd0) begin
            $display("FAIL reset_b got %h exp 0", {b_done, b_pass, b_fail, b_cyc, b_ret, b_last});
            errors++;
        end
        rstn = 1'b0;
        tick();
    endtask

    task automatic test_pass();
        do_clear();
        en = 1'b1;
        pc_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pc = 32'(i * 4);
            instr = 32'h13;
            tick();
        end
        checks++;
        if (a_done !== 1'b0) begin
            $display("FAIL pass_early got %b exp 0", a_done);
            errors++;
        end
        pc = 32'hff;
        tick();
        checks++;
        if ({a_done, a_pass, a_fail} !== 4'b1100) begin
            $display("FAIL pass_status got %b exp 1100", {a_done, a_pass, a_fail});
            errors++;
        end
        checks++;
        if ({a_ret, a_cyc, a_last} !== {32'd65, 32'd65, 32'hff}) begin
            $display("FAIL pass_counts ret %0d cyc %0d last %h exp 65 65 ff", a_ret, a_cyc, a_last);
            errors++;
        end
        pc = 32'h0;
        tick();
        tick();
        checks++;
        if ({a_done, a_pass, a_fail, a_ret, a_cyc} !== {4'b1100, 32'd65, 32'd65}) begin
            $display("FAIL pass_sticky got %b ret %0d cyc %0d exp 1100 65 65",
                     {a_done, a_pass, a_fail}, a_ret, a_cyc);
            errors++;
        end
    endtask

    task automatic test_timeout();
        do_clear();
        en = 1'b1;
        pc_valid = 1'b1;
        for (int i = 0; i < 19; i++) begin
            pc = 32'h100 + 32'(i * 4);
            tick();
        end
        checks++;
        if ({b_done, b_cyc} !== {1'b0, 32'd19}) begin
            $display("FAIL timeout_early done %b cyc %0d exp 0 19", b_done, b_cyc);
            errors++;
        end
        pc = 32'h14c;
        tick();
        checks++;
        if ({b_done, b_pass, b_fail} !== 4'b1001) begin
            $display("FAIL timeout_status got %b exp 1001", {b_done, b_pass, b_fail});
            errors++;
        end
        checks++;
        if ({b_cyc, b_ret, b_last} !== {32'd20, 32'd20, 32'h14c}) begin
            $display("FAIL timeout_counts cyc %0d ret %0d last %h exp 20 20 14c", b_cyc, b_ret, b_last);
            errors++;
        end
        pc = 32'h150;
        tick();
        tick();
        tick();
        checks++;
        if ({b_done, b_fail, b_cyc} !== {1'b1, 2'd1, 32'd20}) begin
            $display("FAIL timeout_frozen done %b code %0d cyc %0d exp 1 1 20", b_done, b_fail, b_cyc);
            errors++;
        end
    endtask

    task automatic test_hang();
        do_clear();
        en = 1'b1;
        pc_valid = 1'b1;
        pc = 32'h40;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (b_done !== 1'b0) begin
            $display("FAIL hang_early got %b exp 0", b_done);
            errors++;
        end
        tick();
        checks++;
        if ({b_done, b_pass, b_fail, b_last, b_ret} !== {4'b1010, 32'h40, 32'd5}) begin
            $display("FAIL hang_status got %b last %h ret %0d exp 1010 40 5",
                     {b_done, b_pass, b_fail}, b_last, b_ret);
            errors++;
        end
    endtask

    task automatic test_priority();
        do_clear();
        en = 1'b1;
        pc_valid = 1'b1;
        pc = 32'h0;
        tick();
        checks++;
        if ({c_done, c_pass, c_fail, c_cyc, c_ret} !== {4'b1100, 32'd1, 32'd1}) begin
            $display("FAIL prio_pass got %b cyc %0d ret %0d exp 1100 1 1",
                     {c_done, c_pass, c_fail}, c_cyc, c_ret);
            errors++;
        end
        do_clear();
        en = 1'b1;
        pc_valid = 1'b0;
        tick();
        checks++;
        if ({c_done, c_pass, c_fail, c_cyc, c_ret} !== {4'b1001, 32'd1, 32'd0}) begin
            $display("FAIL prio_timeout got %b cyc %0d ret %0d exp 1001 1 0",
                     {c_done, c_pass, c_fail}, c_cyc, c_ret);
            errors++;
        end
    endtask

    task automatic test_pause();
        do_clear();
        en = 1'b1;
        pc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h200 + 32'(i * 4);
            tick();
        end
        en = 1'b0;
        pc = 32'hff;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({b_done, b_cyc, b_ret, b_last} !== {1'b0, 32'd5, 32'd5, 32'h210}) begin
            $display("FAIL pause_hold done %b cyc %0d ret %0d last %h exp 0 5 5 210",
                     b_done, b_cyc, b_ret, b_last);
            errors++;
        end
        checks++;
        if (a_done !== 1'b0) begin
            $display("FAIL pause_no_end got %b exp 0", a_done);
            errors++;
        end
        en = 1'b1;
        pc_valid = 1'b0;
        tick();
        tick();
        pc_valid = 1'b1;
        pc = 32'h300;
        tick();
        checks++;
        if ({b_cyc, b_ret, b_last} !== {32'd8, 32'd6, 32'h300}) begin
            $display("FAIL pause_resume cyc %0d ret %0d last %h exp 8 6 300", b_cyc, b_ret, b_last);
            errors++;
        end
    endtask

    task automatic test_restart();
        do_clear();
        en = 1'b1;
        pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h500 + 32'(i * 4);
            tick();
        end
        #2 rstn = 1'b1;
        #1;
        checks++;
        if ({b_done, b_pass, b_fail, b_cyc, b_ret, b_last} !== 100'd0) begin
            $display("FAIL rst_mid_run got %h exp 0", {b_done, b_pass, b_fail, b_cyc, b_ret, b_last});
            errors++;
        end
        tick();
        en = 1'b0;
        rstn = 1'b0;
        tick();
        en = 1'b1;
        pc = 32'h40;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({b_done, b_fail} !== 3'b110) begin
            $display("FAIL rst_hang_setup got %b exp 110", {b_done, b_fail});
            errors++;
        end
        #2 rstn = 1'b1;
        #1;
        checks++;
        if ({b_done, b_pass, b_fail, b_cyc, b_ret, b_last} !== 100'd0) begin
            $display("FAIL rst_in_hang got %h exp 0", {b_done, b_pass, b_fail, b_cyc, b_ret, b_last});
            errors++;
        end
        tick();
        en = 1'b0;
        rstn = 1'b0;
        tick();
        en = 1'b1;
        pc = 32'hff;
        tick();
        checks++;
        if ({a_done, a_pass} !== 2'b11) begin
            $display("FAIL clr_pass_setup got %b exp 11", {a_done, a_pass});
            errors++;
        end
        do_clear();
        checks++;
        if ({a_done, a_pass, a_fail, a_cyc, a_ret, a_last} !== 100'd0) begin
            $display("FAIL clr_in_pass got %h exp 0", {a_done, a_pass, a_fail, a_cyc, a_ret, a_last});
            errors++;
        end
        en = 1'b1;
        pc_valid = 1'b0;
        tick();
        checks++;
        if ({a_done, a_cyc, a_ret} !== {1'b0, 32'd1, 32'd0}) begin
            $display("FAIL clr_rerun done %b cyc %0d ret %0d exp 0 1 0", a_done, a_cyc, a_ret);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_timeout();
        test_hang();
        test_priority();
        test_pause();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
